// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates ALU and load writebacks onto
// the single write port and tracks per-register busy state for hazard stalls.
module regfile_wb_scheduler #(
  parameter int NREG      = 16,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int RR_ENABLE = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            stall,
  output logic            RegWr,
  output logic [AW-1:0]   Waddr,
  output logic [DW-1:0]   Writedata,
  output logic [NREG-1:0] busy
);

  typedef enum logic {RR_ALU, RR_MEM} rr_t;

  rr_t             rr_ptr_q, rr_ptr_d;
  logic            regwr_q, regwr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  // One-hot decode of a register address; out-of-range addresses decode to zero.
  function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (a == AW'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Arbitration: single requester always wins; contention resolved by rr_ptr
  // (or fixed load priority), and the pointer then moves to the loser.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (alu_valid && mem_valid) begin
      if (RR_ENABLE != 0 && rr_ptr_q == RR_ALU) alu_ready = 1'b1;
      else                                      mem_ready = 1'b1;
      rr_ptr_d = alu_ready ? RR_MEM : RR_ALU;
    end else begin
      alu_ready = alu_valid;
      mem_ready = mem_valid;
    end
  end

  // Write-port staging: accepted in-range writes become next cycle's RegWr.
  always_comb begin
    regwr_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_ready && (|decode(alu_addr))) begin
      regwr_d = 1'b1;
      waddr_d = alu_addr;
      wdata_d = alu_data;
    end else if (mem_ready && (|decode(mem_addr))) begin
      regwr_d = 1'b1;
      waddr_d = mem_addr;
      wdata_d = mem_data;
    end
  end

  // Hazard detection against the current scoreboard.
  always_comb begin
    stall = iss_valid &&
            (|(busy_q & (decode(chk_addr1) | decode(chk_addr2) | decode(iss_addr))));
  end

  // Scoreboard next state: clear applied before set so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (regwr_q) busy_d = busy_d & ~decode(waddr_q);
    if (iss_valid && !stall) busy_d = busy_d | decode(iss_addr);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_ptr_q <= RR_ALU;
      regwr_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      regwr_q  <= regwr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign RegWr     = regwr_q;
  assign Waddr     = waddr_q;
  assign Writedata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration table plus hazard,
// out-of-range, fixed-priority and reset corner sequences.
module tb_regfile_wb_scheduler;

  logic        CLK, RESET;
  logic        alu_valid, mem_valid, iss_valid;
  logic [4:0]  alu_addr, mem_addr, iss_addr, chk_addr1, chk_addr2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, stall, RegWr;
  logic [4:0]  Waddr;
  logic [31:0] Writedata;
  logic [15:0] busy;
  logic        fp_alu_ready, fp_mem_ready, fp_stall, fp_RegWr;
  logic [4:0]  fp_Waddr;
  logic [31:0] fp_Writedata;
  logic [15:0] fp_busy;

  regfile_wb_scheduler #(.NREG(16), .AW(5), .DW(32), .RR_ENABLE(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .stall(stall), .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata), .busy(busy)
  );

  regfile_wb_scheduler #(.NREG(16), .AW(5), .DW(32), .RR_ENABLE(0)) dut_fp (
    .CLK(CLK), .RESET(RESET),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(fp_alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(fp_mem_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .stall(fp_stall), .RegWr(fp_RegWr), .Waddr(fp_Waddr), .Writedata(fp_Writedata), .busy(fp_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  task automatic issue(input logic v, input logic [4:0] a, input logic [4:0] c1,
                       input logic [4:0] c2);
    iss_valid = v; iss_addr = a; chk_addr1 = c1; chk_addr2 = c2;
  endtask

  typedef struct {
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic        ear; logic       emr;
    logic        ewr; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic ear, input logic emr, input logic ewr,
                              input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.ear = ear; v.emr = emr; v.ewr = ewr; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    // Registered expectations in each row reflect the edges of earlier rows.
    vecs[0] = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0);
    vecs[1] = mk(1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 0, 0, 0);
    vecs[2] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 1, 32'h11);
    vecs[3] = mk(1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1, 2, 32'h22);
    vecs[4] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1, 1, 32'h11);
    vecs[5] = mk(0, 0, 0,     0, 0, 0,     0, 0, 1, 2, 32'h22);
    vecs[6] = mk(0, 0, 0,     1, 3, 32'h33, 0, 1, 0, 2, 32'h22);
    vecs[7] = mk(1, 4, 32'h44, 0, 0, 0,     1, 0, 1, 3, 32'h33);
    vecs[8] = mk(1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 1, 4, 32'h44);
    vecs[9] = mk(0, 0, 0,     0, 0, 0,     0, 0, 1, 5, 32'h55);

    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0);

    @(negedge CLK);
    chk("reset_regwr", 32'(RegWr), 32'd0);
    chk("reset_waddr", 32'(Waddr), 32'd0);
    chk("reset_wdata", Writedata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    #1 RESET = 1'b0;

    // Arbitration / write pipeline table.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      chk($sformatf("tbl%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      chk($sformatf("tbl%0d_regwr", i),     32'(RegWr),     32'(vecs[i].ewr));
      chk($sformatf("tbl%0d_waddr", i),     32'(Waddr),     32'(vecs[i].ewa));
      chk($sformatf("tbl%0d_wdata", i),     Writedata,      vecs[i].ewd);
      chk($sformatf("tbl%0d_busy", i),      32'(busy),      32'd0);
    end

    // RAW: r5 marked busy, dependent issue stalls until after the commit cycle.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    issue(1, 5, 0, 0);
    #1 chk("raw_first_issue_stall", 32'(stall), 32'd0);
    @(negedge CLK);
    issue(1, 9, 5, 0);
    drive(0, 0, 0, 1, 5, 32'hCAFE);
    #1;
    chk("raw_busy_set", 32'(busy), 32'h0020);
    chk("raw_stall", 32'(stall), 32'd1);
    chk("raw_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("raw_commit_regwr", 32'(RegWr), 32'd1);
    chk("raw_commit_waddr", 32'(Waddr), 32'd5);
    chk("raw_commit_wdata", Writedata, 32'hCAFE);
    chk("raw_commit_stall", 32'(stall), 32'd1);
    chk("raw_commit_busy", 32'(busy), 32'h0020);
    @(negedge CLK);
    #1;
    chk("raw_after_stall", 32'(stall), 32'd0);
    chk("raw_after_busy", 32'(busy), 32'd0);
    chk("raw_after_regwr", 32'(RegWr), 32'd0);
    issue(0, 0, 0, 0);

    // WAW: r7 busy, re-issue to r7 stalls until its writeback retires.
    @(negedge CLK);
    issue(1, 7, 0, 0);
    #1 chk("waw_first_stall", 32'(stall), 32'd0);
    @(negedge CLK);
    #1;
    chk("waw_busy", 32'(busy), 32'h0080);
    chk("waw_stall", 32'(stall), 32'd1);
    @(negedge CLK);
    drive(1, 7, 32'h77, 0, 0, 0);
    #1;
    chk("waw_busy_hold", 32'(busy), 32'h0080);
    chk("waw_stall_hold", 32'(stall), 32'd1);
    chk("waw_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("waw_commit_regwr", 32'(RegWr), 32'd1);
    chk("waw_commit_waddr", 32'(Waddr), 32'd7);
    chk("waw_commit_stall", 32'(stall), 32'd1);
    chk("waw_commit_busy", 32'(busy), 32'h0080);
    @(negedge CLK);
    #1;
    chk("waw_after_busy", 32'(busy), 32'd0);
    chk("waw_after_stall", 32'(stall), 32'd0);
    issue(0, 0, 0, 0);

    // Same-edge set and clear on r8 (not busy while being written): set wins.
    @(negedge CLK);
    drive(1, 8, 32'h88, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    issue(1, 8, 0, 0);
    #1;
    chk("setclr_regwr", 32'(RegWr), 32'd1);
    chk("setclr_waddr", 32'(Waddr), 32'd8);
    chk("setclr_stall", 32'(stall), 32'd0);
    @(negedge CLK);
    issue(0, 0, 0, 0);
    drive(1, 8, 32'h89, 0, 0, 0);
    #1 chk("setclr_busy", 32'(busy), 32'h0100);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1 chk("setclr_cleared", 32'(busy), 32'd0);

    // Out-of-range write and issue.
    @(negedge CLK);
    drive(1, 20, 32'h1234, 0, 0, 0);
    issue(1, 20, 20, 21);
    #1;
    chk("oor_alu_ready", 32'(alu_ready), 32'd1);
    chk("oor_stall", 32'(stall), 32'd0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0);
    #1;
    chk("oor_regwr", 32'(RegWr), 32'd0);
    chk("oor_busy", 32'(busy), 32'd0);

    // Fixed priority instance: load wins every contended cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1, 1, 32'hA1, 1, 2, 32'hB2);
      #1;
      chk($sformatf("fp%0d_mem_ready", i), 32'(fp_mem_ready), 32'd1);
      chk($sformatf("fp%0d_alu_ready", i), 32'(fp_alu_ready), 32'd0);
    end
    @(negedge CLK);
    drive(1, 1, 32'hA1, 0, 0, 0);
    #1;
    chk("fp_alu_granted", 32'(fp_alu_ready), 32'd1);
    chk("fp_mem_idle", 32'(fp_mem_ready), 32'd0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    // Reset mid-write: ALU wins a contended cycle (pointer moves to MEM),
    // reset lands inside the RegWr cycle, then ALU must be preferred again.
    @(negedge CLK);
    drive(1, 3, 32'hDEADBEEF, 1, 4, 32'h44);
    issue(1, 10, 0, 0);
    #1 chk("rst_pre_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge CLK);
    #1;
    issue(0, 0, 0, 0);
    chk("rst_pre_regwr", 32'(RegWr), 32'd1);
    chk("rst_pre_busy", 32'(busy), 32'h0400);
    #1 RESET = 1'b1;
    #1;
    chk("rst_mid_regwr", 32'(RegWr), 32'd0);
    chk("rst_mid_waddr", 32'(Waddr), 32'd0);
    chk("rst_mid_wdata", Writedata, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    #1 RESET = 1'b0;
    @(negedge CLK);
    #1;
    chk("rst_post_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_post_mem_ready", 32'(mem_ready), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
